// File: rtl/render_pkg.sv
// Shared render-pipeline types, screen geometry and FSM encoding.
// Used by the line rasterizer and its Bresenham step unit.
package render_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  typedef logic signed [15:0] coord_t;
  typedef logic [7:0]         color_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } state_e;

  function automatic logic on_screen(
    input int x,
    input int y
  );
    return (x >= 0) && (x < H_RES) &&
           (y >= 0) && (y < V_RES);
  endfunction

endpackage

// File: rtl/line_step_unit.sv
// Combinational Bresenham step: next (cx, cy, err) from the
// current point and the line's setup terms.
module line_step_unit
  import render_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int EW      = COORD_W + 2
) (
  input  logic signed [COORD_W-1:0] cx,
  input  logic signed [COORD_W-1:0] cy,
  input  logic signed [EW-1:0]      err,
  input  logic signed [EW-1:0]      dx,
  input  logic signed [EW-1:0]      dy,
  input  logic                      sx_neg,
  input  logic                      sy_neg,
  output logic signed [COORD_W-1:0] nx,
  output logic signed [COORD_W-1:0] ny,
  output logic signed [EW-1:0]      nerr
);

  localparam logic [COORD_W-1:0] ONE =
    {{(COORD_W-1){1'b0}}, 1'b1};

  logic signed [EW:0] e2;

  // Both axis decisions use the pre-step error term.
  always_comb begin
    e2   = $signed({err, 1'b0});
    nx   = cx;
    ny   = cy;
    nerr = err;
    if (e2 >= dy) begin
      nerr = nerr + dy;
      nx   = sx_neg ? cx - ONE : cx + ONE;
    end
    if (e2 <= dx) begin
      nerr = nerr + dx;
      ny   = sy_neg ? cy - ONE : cy + ONE;
    end
  end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham edge rasterizer: one edge in, one pixel write per cycle out.
// Build option LINE_CLIP_EN suppresses off-screen pixels.
module line_rasterizer
  import render_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0]        color,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [X_W-1:0]            pix_x,
  output logic [Y_W-1:0]            pix_y,
  output logic [COLOR_W-1:0]        pix_color,
  output logic                      busy,
  output logic                      line_done
);

  localparam int EW = COORD_W + 2;

  state_e state;

  logic signed [COORD_W-1:0] lx0, ly0, lx1, ly1;
  logic signed [COORD_W-1:0] cx, cy, nx, ny;
  logic signed [EW-1:0]      dx, dy, err, nerr;
  logic signed [EW-1:0]      ddx, ddy, adx, ady;
  logic sx_neg, sy_neg;
  logic adv, at_end;
  logic vis_start, vis_next;

  always_comb begin
    ddx = EW'(lx1) - EW'(lx0);
    ddy = EW'(ly1) - EW'(ly0);
    adx = ddx[EW-1] ? -ddx : ddx;
    ady = ddy[EW-1] ? -ddy : ddy;
  end

  assign at_end = (cx == lx1) && (cy == ly1);
  // A suppressed pixel never waits on the writer.
  assign adv = (state == DRAW) &&
               (!pix_valid || pix_ready);

`ifdef LINE_CLIP_EN
  assign vis_start = on_screen(int'(lx0), int'(ly0));
  assign vis_next  = on_screen(int'(nx), int'(ny));
`else
  assign vis_start = 1'b1;
  assign vis_next  = 1'b1;
`endif

  line_step_unit #(
    .COORD_W (COORD_W),
    .EW      (EW)
  ) u_step (
    .cx     (cx),
    .cy     (cy),
    .err    (err),
    .dx     (dx),
    .dy     (dy),
    .sx_neg (sx_neg),
    .sy_neg (sy_neg),
    .nx     (nx),
    .ny     (ny),
    .nerr   (nerr)
  );

  assign pix_x = cx[X_W-1:0];
  assign pix_y = cy[Y_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      line_done <= 1'b0;
      pix_color <= '0;
      lx0       <= '0;
      ly0       <= '0;
      lx1       <= '0;
      ly1       <= '0;
      cx        <= '0;
      cy        <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            lx0       <= x0;
            ly0       <= y0;
            lx1       <= x1;
            ly1       <= y1;
            pix_color <= color;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          dx        <= adx;
          dy        <= -ady;
          err       <= adx - ady;
          sx_neg    <= !(lx0 < lx1);
          sy_neg    <= !(ly0 < ly1);
          cx        <= lx0;
          cy        <= ly0;
          pix_valid <= vis_start;
          state     <= DRAW;
        end
        DRAW: begin
          if (adv) begin
            if (at_end) begin
              pix_valid <= 1'b0;
              line_done <= 1'b1;
              state     <= DONE;
            end else begin
              cx        <= nx;
              cy        <= ny;
              err       <= nerr;
              pix_valid <= vis_next;
            end
          end
        end
        DONE: begin
          line_done <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed self-checking bench for line_rasterizer.
// Honours LINE_CLIP_EN to pick the matching clip expectations.
module tb_line_rasterizer;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x0, y0, x1, y1;
  logic [7:0]         color;
  logic               pix_valid;
  logic               pix_ready;
  logic [9:0]         pix_x;
  logic [8:0]         pix_y;
  logic [7:0]         pix_color;
  logic               busy;
  logic               line_done;

  line_rasterizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .color     (color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .busy      (busy),
    .line_done (line_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int qx[$];
  int qy[$];
  int qc[$];
  int lat, done_k, last_hs, stall_bad, done_seen;

  // Offers one edge while idle and captures every handshaked pixel.
  task automatic drive_edge(
    input int ax, input int ay,
    input int bx, input int by,
    input logic [7:0] col,
    input bit bp
  );
    int rc;
    bit pstall;
    logic [9:0] px;
    logic [8:0] py;
    logic [7:0] pc;
    qx.delete(); qy.delete(); qc.delete();
    lat = -1; done_k = -1; last_hs = -1;
    stall_bad = 0; done_seen = 0;
    rc = 0; pstall = 1'b0;
    px = '0; py = '0; pc = '0;
    @(negedge clk);
    x0 = 16'(ax); y0 = 16'(ay);
    x1 = 16'(bx); y1 = 16'(by);
    color = col;
    in_valid = 1'b1;
    pix_ready = 1'b1;
    for (int k = 1; k < 300 && done_seen == 0; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (pstall && (!pix_valid || pix_x !== px ||
          pix_y !== py || pix_color !== pc))
        stall_bad++;
      if (pix_valid && lat < 0) lat = k;
      if (line_done) begin
        done_seen = 1;
        done_k = k;
      end
      pix_ready = bp ? (rc % 3 == 0) : 1'b1;
      if (pix_valid) rc++;
      if (pix_valid && pix_ready) begin
        qx.push_back(int'(pix_x));
        qy.push_back(int'(pix_y));
        qc.push_back(int'(pix_color));
        last_hs = k;
      end
      pstall = pix_valid && !pix_ready;
      px = pix_x; py = pix_y; pc = pix_color;
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    pix_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    color = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || pix_valid !== 1'b0 ||
        busy !== 1'b0 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b pv=%b busy=%b done=%b want 1 0 0 0",
               in_ready, pix_valid, busy, line_done);
    end
    checks++;
    if (pix_x !== 10'd0 || pix_y !== 9'd0 || pix_color !== 8'd0) begin
      errors++;
      $display("FAIL reset_pix: got %0d,%0d,%h want 0,0,00",
               pix_x, pix_y, pix_color);
    end
  endtask

  task automatic test_horizontal();
    drive_edge(10, 20, 14, 20, 8'hE0, 1'b0);
    checks++;
    if (qx.size() != 5) begin
      errors++;
      $display("FAIL horiz_count: got %0d want 5", qx.size());
    end
    for (int i = 0; i < qx.size() && i < 5; i++) begin
      checks++;
      if (qx[i] != 10 + i || qy[i] != 20 || qc[i] != 'hE0) begin
        errors++;
        $display("FAIL horiz_pix[%0d]: got (%0d,%0d,%h) want (%0d,20,e0)",
                 i, qx[i], qy[i], qc[i], 10 + i);
      end
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL horiz_latency: got %0d want 2", lat);
    end
    checks++;
    if (done_seen != 1 || done_k != last_hs + 1) begin
      errors++;
      $display("FAIL horiz_done: got cycle %0d want %0d",
               done_k, last_hs + 1);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL horiz_idle: got rdy=%b busy=%b done=%b want 1 0 0",
               in_ready, busy, line_done);
    end
  endtask

  task automatic test_steep();
    int ex[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    drive_edge(0, 0, 3, 7, 8'h1C, 1'b0);
    checks++;
    if (qx.size() != 8) begin
      errors++;
      $display("FAIL steep_count: got %0d want 8", qx.size());
    end
    for (int i = 0; i < qx.size() && i < 8; i++) begin
      checks++;
      if (qx[i] != ex[i] || qy[i] != i) begin
        errors++;
        $display("FAIL steep_pix[%0d]: got (%0d,%0d) want (%0d,%0d)",
                 i, qx[i], qy[i], ex[i], i);
      end
    end
    drive_edge(3, 7, 0, 0, 8'h03, 1'b0);
    checks++;
    if (qx.size() != 8 || done_seen != 1) begin
      errors++;
      $display("FAIL steep_rev_count: got %0d done=%0d want 8 done=1",
               qx.size(), done_seen);
    end else begin
      checks++;
      if (qx[0] != 3 || qy[0] != 7 || qx[7] != 0 || qy[7] != 0) begin
        errors++;
        $display("FAIL steep_rev_ends: got (%0d,%0d)..(%0d,%0d) want (3,7)..(0,0)",
                 qx[0], qy[0], qx[7], qy[7]);
      end
    end
  endtask

  task automatic test_backpressure();
    drive_edge(0, 0, 4, 4, 8'h5A, 1'b1);
    checks++;
    if (qx.size() != 5 || done_seen != 1) begin
      errors++;
      $display("FAIL bp_count: got %0d done=%0d want 5 done=1",
               qx.size(), done_seen);
    end
    for (int i = 0; i < qx.size() && i < 5; i++) begin
      checks++;
      if (qx[i] != i || qy[i] != i || qc[i] != 'h5A) begin
        errors++;
        $display("FAIL bp_pix[%0d]: got (%0d,%0d,%h) want (%0d,%0d,5a)",
                 i, qx[i], qy[i], qc[i], i, i);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad);
    end
  endtask

  task automatic test_point();
    int n1, bad_rdy, px1, py1, seen;
    n1 = 0; bad_rdy = 0; px1 = -1; py1 = -1; seen = 0;
    @(negedge clk);
    x0 = 16'sd5; y0 = 16'sd5; x1 = 16'sd5; y1 = 16'sd5;
    color = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    x0 = 16'sd7; y0 = 16'sd7; x1 = 16'sd8; y1 = 16'sd7;
    color = 8'h11;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      if (in_ready) bad_rdy++;
      if (pix_valid) begin
        n1++;
        px1 = int'(pix_x);
        py1 = int'(pix_y);
      end
      if (line_done) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (seen != 1 || n1 != 1 || px1 != 5 || py1 != 5) begin
      errors++;
      $display("FAIL point_pix: got n=%0d (%0d,%0d) done=%0d want n=1 (5,5) done=1",
               n1, px1, py1, seen);
    end
    checks++;
    if (bad_rdy != 0) begin
      errors++;
      $display("FAIL point_busy_ready: got %0d cycles ready want 0", bad_rdy);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL point_ready_back: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL point_second_accept: got busy=%b rdy=%b want 1 0",
               busy, in_ready);
    end
    qx.delete(); qy.delete();
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (pix_valid) begin
        qx.push_back(int'(pix_x));
        qy.push_back(int'(pix_y));
      end
      if (line_done) seen = 1;
    end
    checks++;
    if (seen != 1 || qx.size() != 2) begin
      errors++;
      $display("FAIL point_second_count: got %0d done=%0d want 2 done=1",
               qx.size(), seen);
    end else begin
      checks++;
      if (qx[0] != 7 || qy[0] != 7 || qx[1] != 8 || qy[1] != 7) begin
        errors++;
        $display("FAIL point_second_pix: got (%0d,%0d),(%0d,%0d) want (7,7),(8,7)",
                 qx[0], qy[0], qx[1], qy[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt, bad;
    cnt = 0; bad = 0;
    @(negedge clk);
    x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd9; y1 = 16'sd0;
    color = 8'h80;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && cnt < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (pix_valid) cnt++;
    end
    checks++;
    if (cnt != 3) begin
      errors++;
      $display("FAIL rstmid_reach: got %0d pixels want 3", cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || in_ready !== 1'b1 ||
        busy !== 1'b0 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: got pv=%b rdy=%b busy=%b done=%b want 0 1 0 0",
               pix_valid, in_ready, busy, line_done);
    end
    repeat (15) begin
      @(negedge clk);
      if (pix_valid || line_done || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_clip();
    int exp_x[$];
    int n_off;
`ifdef LINE_CLIP_EN
    exp_x = '{0, 1, 2};
    n_off = 0;
`else
    exp_x = '{1022, 1023, 0, 1, 2};
    n_off = 5;
`endif
    drive_edge(-2, 0, 2, 0, 8'hC3, 1'b0);
    checks++;
    if (qx.size() != exp_x.size() || done_seen != 1) begin
      errors++;
      $display("FAIL clip_count: got %0d done=%0d want %0d done=1",
               qx.size(), done_seen, exp_x.size());
    end
    for (int i = 0; i < qx.size() && i < exp_x.size(); i++) begin
      checks++;
      if (qx[i] != exp_x[i] || qy[i] != 0) begin
        errors++;
        $display("FAIL clip_pix[%0d]: got (%0d,%0d) want (%0d,0)",
                 i, qx[i], qy[i], exp_x[i]);
      end
    end
    drive_edge(-5, -5, -1, -1, 8'h0F, 1'b0);
    checks++;
    if (qx.size() != n_off || done_seen != 1) begin
      errors++;
      $display("FAIL clip_offscreen: got %0d done=%0d want %0d done=1",
               qx.size(), done_seen, n_off);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_backpressure();
    test_point();
    test_reset_mid();
    test_clip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
